// File: rtl/sdpr_stream_reader.sv
// Port-B read engine for the simple dual-port RAM: issues burst reads, absorbs the
// RAM latency and streams words out via valid/ready. Optional check: SDPR_PATTERN_CHECK_EN.
module sdpr_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
`ifdef SDPR_PATTERN_CHECK_EN
  ,
  output logic [ADDR_W:0]   o_err_cnt,
  output logic              o_pass
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  logic [1:0]            r_state;
  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W:0]       r_len;
  logic [ADDR_W:0]       r_issued;
  logic [ADDR_W:0]       r_push_cnt;
  logic [RD_LATENCY-1:0] r_trk;
  logic [DATA_W:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_start_acc;
  logic [CNT_W-1:0]      w_inflight;
  logic [CNT_W-1:0]      w_credit;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_pop;
  logic [DATA_W:0]       w_head;
  logic                  w_last_pop;
  logic                  w_drain_done;

  // NOTE: always_comb assigns a default before any loop or branch, so no latch is inferred.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_trk[i]);
    end
  end

  assign w_start_acc  = (r_state == ST_IDLE) && i_start;
  assign w_credit     = w_inflight + r_count;
  assign o_rd_en      = (r_state == ST_ISSUE) && (w_credit < CNT_W'(FIFO_DEPTH));
  assign o_rd_addr    = r_base + r_issued[ADDR_W-1:0];
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);

  assign w_push       = r_trk[RD_LATENCY-1];
  assign w_push_last  = (r_push_cnt == r_len - LEN_ONE);
  assign o_valid      = (r_count != '0);
  assign w_pop        = o_valid && i_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign o_data       = o_valid ? w_head[DATA_W-1:0] : '0;
  assign o_last       = o_valid && w_head[DATA_W];
  assign w_last_pop   = w_pop && o_last;
  // The last word leaving with nothing in flight means the burst is fully drained.
  assign w_drain_done = (r_state == ST_DRAIN) && w_last_pop &&
                        (w_inflight == '0) && (r_count == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_base   <= i_base_addr;
          r_len    <= i_len;
          r_issued <= '0;
          r_state  <= (i_len == '0) ? ST_DONE : ST_ISSUE;
        end
        ST_ISSUE: if (o_rd_en) begin
          r_issued <= r_issued + LEN_ONE;
          if (r_issued + LEN_ONE == r_len) r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (w_drain_done) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trk      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_push_cnt <= '0;
    end else begin
      r_trk[0] <= o_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
      if (w_start_acc)  r_push_cnt <= '0;
      else if (w_push)  r_push_cnt <= r_push_cnt + LEN_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; o_valid gates every read of it, so stale contents never escape.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_last, i_rd_data};
  end

`ifdef SDPR_PATTERN_CHECK_EN
  logic [ADDR_W:0]   r_pop_cnt;
  logic [ADDR_W:0]   r_err_cnt;
  logic              r_pass;
  logic [ADDR_W-1:0] w_src_addr;
  logic              w_mismatch;
  logic [ADDR_W:0]   w_err_nxt;

  // Source address is formed at ADDR_W bits first so it wraps before zero-extension.
  assign w_src_addr = r_base + r_pop_cnt[ADDR_W-1:0];
  assign w_mismatch = w_pop && (o_data != DATA_W'(w_src_addr));
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + LEN_ONE : r_err_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pop_cnt <= '0;
      r_err_cnt <= '0;
      r_pass    <= 1'b0;
    end else if (w_start_acc) begin
      r_pop_cnt <= '0;
      r_err_cnt <= '0;
      r_pass    <= (i_len == '0);
    end else begin
      r_err_cnt <= w_err_nxt;
      if (w_pop)        r_pop_cnt <= r_pop_cnt + LEN_ONE;
      if (w_drain_done) r_pass    <= (w_err_nxt == '0);
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign o_pass    = r_pass;
`endif

endmodule
